// File: rtl/predecode_queue_pkg.sv
// Shared constants and types for the branch pre-decode queue.
// Selector field positions, selector encodings, MIPS opcode/funct/rt values,
// and helpers that size the stored queue entry.
package predecode_queue_pkg;

    localparam int unsigned SEL_W = 5;

    // Selector bit positions
    localparam int unsigned SEL_PHT   = 0;
    localparam int unsigned SEL_TAKEN = 1;
    localparam int unsigned SEL_BTB   = 2;
    localparam int unsigned SEL_IJTC  = 3;
    localparam int unsigned SEL_RSA   = 4;

    // Selector encodings per branch class
    localparam logic [SEL_W-1:0] SEL_NONE      = '0;
    localparam logic [SEL_W-1:0] SEL_COND      = SEL_W'((1 << SEL_PHT) | (1 << SEL_BTB));
    localparam logic [SEL_W-1:0] SEL_COND_LINK = SEL_W'((1 << SEL_PHT) | (1 << SEL_RSA));
    localparam logic [SEL_W-1:0] SEL_JUMP      = SEL_W'((1 << SEL_TAKEN) | (1 << SEL_BTB));
    localparam logic [SEL_W-1:0] SEL_INDIRECT  = SEL_W'((1 << SEL_TAKEN) | (1 << SEL_IJTC));
    localparam logic [SEL_W-1:0] SEL_RETURN    = SEL_W'((1 << SEL_TAKEN) | (1 << SEL_RSA));

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;

    // SPECIAL funct codes
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    // REGIMM rt codes
    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    // Return-address register
    localparam logic [4:0] REG_RA = 5'd31;

    // Per-instruction decode result
    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             call;
        logic             ret;
    } br_dec_t;

    // Index width that stays legal for a single-slot packet
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Stored entry: sel + call + ret + has_br + first_br + ds_next + pc
    function automatic int unsigned entry_w(input int unsigned fw, input int unsigned pc_w);
        return fw * SEL_W + fw + fw + 1 + idx_w(fw) + 1 + pc_w;
    endfunction

endpackage

// File: rtl/predecode_queue_br_sel_decoder.sv
// Single-instruction branch classifier: one MIPS word -> 5-bit predictor
// selector plus call/return flags, all forced to zero on an SCT miss.
module br_sel_decoder
    import predecode_queue_pkg::*;
(
    input  logic [31:0] inst,
    input  logic        sct_valid,
    output br_dec_t     dec_c
);

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] funct;
    logic       unused_imm;

    assign op         = inst[31:26];
    assign rs         = inst[25:21];
    assign rt         = inst[20:16];
    assign funct      = inst[5:0];
    assign unused_imm = ^inst[15:6];

    // Classify the instruction by opcode, then rt/funct where needed
    always_comb begin
        dec_c = '0;
        case (op)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: dec_c.sel = SEL_COND;
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ, RT_BGEZ: dec_c.sel = SEL_COND;
                    RT_BLTZAL, RT_BGEZAL: begin
                        dec_c.sel  = SEL_COND_LINK;
                        dec_c.call = 1'b1;
                    end
                    default: dec_c.sel = SEL_NONE;
                endcase
            end
            OP_J: dec_c.sel = SEL_JUMP;
            OP_JAL: begin
                dec_c.sel  = SEL_JUMP;
                dec_c.call = 1'b1;
            end
            OP_SPECIAL: begin
                if (funct == FN_JALR) begin
                    dec_c.sel  = SEL_INDIRECT;
                    dec_c.call = 1'b1;
                end else if (funct == FN_JR) begin
                    if (rs == REG_RA) begin
                        dec_c.sel = SEL_RETURN;
                        dec_c.ret = 1'b1;
                    end else begin
                        dec_c.sel = SEL_INDIRECT;
                    end
                end
            end
            default: dec_c.sel = SEL_NONE;
        endcase
        if (!sct_valid) begin
            dec_c = '0;
        end
    end

endmodule

// File: rtl/predecode_queue.sv
// Fetch-packet branch pre-decoder with a DEPTH-entry valid/ready FIFO.
// Decodes FETCH_WIDTH instructions per packet, summarises the first branch,
// and buffers the result for the branch predictor.
// Optional PDQ_BYPASS_EN: an empty queue forwards the decoded packet to the
// outputs in the same cycle and skips storage when it is consumed at once.
module predecode_queue
    import predecode_queue_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH = 4,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned PC_W        = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [FETCH_WIDTH*32-1:0]            in_inst,
    input  logic [PC_W-1:0]                      in_pc,
    input  logic                                 in_sct_valid,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [FETCH_WIDTH*SEL_W-1:0]         out_sel,
    output logic [FETCH_WIDTH-1:0]               out_call,
    output logic [FETCH_WIDTH-1:0]               out_ret,
    output logic                                 out_has_br,
    output logic [idx_w(FETCH_WIDTH)-1:0]        out_first_br,
    output logic                                 out_ds_next,
    output logic [PC_W-1:0]                      out_pc,
    output logic [$clog2(DEPTH):0]               count
);

    localparam int unsigned FW  = FETCH_WIDTH;
    localparam int unsigned FBW = idx_w(FW);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned EW  = entry_w(FW, PC_W);

    logic [FW*SEL_W-1:0] dec_sel_c;
    logic [FW-1:0]       dec_call_c;
    logic [FW-1:0]       dec_ret_c;
    logic                dec_has_c;
    logic [FBW-1:0]      dec_first_c;
    logic                dec_ds_c;
    logic [EW-1:0]       in_entry_c;
    logic [EW-1:0]       head_c;

    logic [EW-1:0]       mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;

    logic                empty_c;
    logic                bypass_take_c;
    logic                enq_c;
    logic                deq_c;

    // One decoder per slot
    for (genvar g = 0; g < FW; g++) begin : g_dec
        br_dec_t slot_dec_c;

        br_sel_decoder u_dec (
            .inst      (in_inst[g*32 +: 32]),
            .sct_valid (in_sct_valid),
            .dec_c     (slot_dec_c)
        );

        assign dec_sel_c[g*SEL_W +: SEL_W] = slot_dec_c.sel;
        assign dec_call_c[g]               = slot_dec_c.call;
        assign dec_ret_c[g]                = slot_dec_c.ret;
    end

    // Lowest slot with a nonzero selector
    always_comb begin
        dec_first_c = '0;
        for (int i = int'(FW) - 1; i >= 0; i--) begin
            if (dec_sel_c[i*SEL_W +: SEL_W] != '0) begin
                dec_first_c = FBW'(i);
            end
        end
    end

    assign dec_has_c  = |dec_sel_c;
    assign dec_ds_c   = dec_has_c && (dec_first_c == FBW'(FW - 1));
    assign in_entry_c = {in_pc, dec_ds_c, dec_first_c, dec_has_c, dec_ret_c, dec_call_c, dec_sel_c};

    assign empty_c  = (count == '0);
    assign in_ready = (count != CW'(DEPTH));

    // Head selection: stored entry, or the live packet when bypassing
    always_comb begin
        out_valid     = !empty_c;
        head_c        = empty_c ? '0 : mem[rd_ptr];
        bypass_take_c = 1'b0;
`ifdef PDQ_BYPASS_EN
        if (empty_c && !flush) begin
            out_valid     = in_valid;
            head_c        = in_valid ? in_entry_c : '0;
            bypass_take_c = in_valid && out_ready;
        end
`endif
    end

    assign {out_pc, out_ds_next, out_first_br, out_has_br, out_ret, out_call, out_sel} = head_c;

    assign enq_c = in_valid && in_ready && !bypass_take_c && !flush;
    assign deq_c = !empty_c && out_ready && !flush;

    // Entry storage
    always_ff @(posedge clk) begin
        if (enq_c) begin
            mem[wr_ptr] <= in_entry_c;
        end
    end

    // Pointers and occupancy; flush wins over any transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq_c, deq_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_predecode_queue.sv
// Self-checking bench for predecode_queue: directed scenarios plus random
// traffic compared against a packet-level queue model.
module tb_predecode_queue;

    localparam int FW    = 4;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
`ifdef PDQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [FW*32-1:0] in_inst = '0;
    logic [PC_W-1:0] in_pc = '0;
    logic            in_sct_valid = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [FW*5-1:0] out_sel;
    logic [FW-1:0]   out_call;
    logic [FW-1:0]   out_ret;
    logic            out_has_br;
    logic [1:0]      out_first_br;
    logic            out_ds_next;
    logic [PC_W-1:0] out_pc;
    logic [2:0]      count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    predecode_queue #(.FETCH_WIDTH(FW), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .in_sct_valid (in_sct_valid),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sel      (out_sel),
        .out_call     (out_call),
        .out_ret      (out_ret),
        .out_has_br   (out_has_br),
        .out_first_br (out_first_br),
        .out_ds_next  (out_ds_next),
        .out_pc       (out_pc),
        .count        (count)
    );

    typedef struct {
        logic [19:0] sel;
        logic [3:0]  call;
        logic [3:0]  ret;
        logic        has_br;
        logic [1:0]  first_br;
        logic        ds_next;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Branch classes written straight from the instruction-set rules
    function automatic void ref_decode(input logic [31:0] w, input logic sct,
                                       output logic [4:0] sel, output logic call, output logic ret);
        int op, rs, rt, fn;
        op = int'(w[31:26]);
        rs = int'(w[25:21]);
        rt = int'(w[20:16]);
        fn = int'(w[5:0]);
        sel = 5'b0;
        call = 1'b0;
        ret = 1'b0;
        if (!sct) return;
        if (op >= 4 && op <= 7) sel = 5'b00101;
        else if (op == 1 && rt <= 1) sel = 5'b00101;
        else if (op == 1 && (rt == 16 || rt == 17)) begin sel = 5'b10001; call = 1'b1; end
        else if (op == 2 || op == 3) begin sel = 5'b00110; call = (op == 3); end
        else if (op == 0 && fn == 9) begin sel = 5'b01010; call = 1'b1; end
        else if (op == 0 && fn == 8) begin
            if (rs == 31) begin sel = 5'b10010; ret = 1'b1; end
            else sel = 5'b01010;
        end
    endfunction

    function automatic exp_t mk_exp(input logic [127:0] inst, input logic sct, input logic [31:0] pc);
        exp_t e;
        logic [4:0] s;
        logic c, r;
        e.sel = '0; e.call = '0; e.ret = '0;
        e.has_br = 1'b0; e.first_br = 2'd0; e.ds_next = 1'b0; e.pc = pc;
        for (int i = 0; i < FW; i++) begin
            ref_decode(inst[i*32 +: 32], sct, s, c, r);
            e.sel[i*5 +: 5] = s;
            e.call[i] = c;
            e.ret[i] = r;
            if (s != 5'b0 && !e.has_br) begin
                e.has_br = 1'b1;
                e.first_br = 2'(i);
            end
        end
        e.ds_next = e.has_br && (e.first_br == 2'(FW - 1));
        return e;
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 7))
            0: w[31:26] = 6'(4 + $urandom_range(0, 3));
            1: begin
                w[31:26] = 6'd1;
                w[20:16] = 5'(16 * $urandom_range(0, 1) + $urandom_range(0, 1));
            end
            2: w[31:26] = 6'(2 + $urandom_range(0, 1));
            3: begin
                w[31:26] = 6'd0;
                w[5:0] = 6'd8;
                if ($urandom_range(0, 1) == 1) w[25:21] = 5'd31;
            end
            4: begin
                w[31:26] = 6'd0;
                w[5:0] = 6'd9;
            end
            default: w = w;
        endcase
        return w;
    endfunction

    task automatic rnd_pkt();
        for (int i = 0; i < FW; i++) in_inst[i*32 +: 32] = rnd_inst();
        in_pc = $urandom;
    endtask

    // One clock: inputs already driven after negedge; check, advance model, move to next negedge
    task automatic step();
        exp_t cur, head;
        bit ev, byp_now, acc, take;
        #1;
        cur = mk_exp(in_inst, in_sct_valid, in_pc);
        byp_now = BYP && (q.size() == 0) && !flush;
        ev = (q.size() != 0) || (byp_now && in_valid);
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("count", 64'(count), 64'(q.size()));
        chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
        if (ev) begin
            head = (q.size() != 0) ? q[0] : cur;
            chk("head_sel", 64'(out_sel), 64'(head.sel));
            chk("head_call", 64'(out_call), 64'(head.call));
            chk("head_ret", 64'(out_ret), 64'(head.ret));
            chk("head_has_br", 64'(out_has_br), 64'(head.has_br));
            chk("head_first_br", 64'(out_first_br), 64'(head.first_br));
            chk("head_ds_next", 64'(out_ds_next), 64'(head.ds_next));
            chk("head_pc", 64'(out_pc), 64'(head.pc));
        end
        if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < DEPTH);
            take = ev && out_ready;
            if (take && q.size() != 0) void'(q.pop_front());
            if (acc && !(byp_now && out_ready)) q.push_back(cur);
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sel", 64'(out_sel), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Decode reference packet with SCT hit
        in_inst = {32'h0080_F809, 32'h03E0_0008, 32'h0411_0004, 32'h1022_0003};
        in_sct_valid = 1'b1;
        in_pc = 32'h0000_1000;
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        #1;
        chk("dec_sel", 64'(out_sel), 64'(20'b01010_10010_10001_00101));
        chk("dec_call", 64'(out_call), 64'(4'b1010));
        chk("dec_ret", 64'(out_ret), 64'(4'b0100));
        chk("dec_first_br", 64'(out_first_br), 64'd0);
        chk("dec_has_br", 64'(out_has_br), 64'd1);
        step();

        // Same packet with SCT miss, consuming the first one
        in_sct_valid = 1'b0;
        in_pc = 32'h0000_1010;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("nosct_valid", 64'(out_valid), 64'd1);
        chk("nosct_sel", 64'(out_sel), 64'd0);
        chk("nosct_call", 64'(out_call), 64'd0);
        chk("nosct_ret", 64'(out_ret), 64'd0);
        chk("nosct_has_br", 64'(out_has_br), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_sct_valid = 1'b1;

        // Fill past capacity; fifth packet must be held
        for (int i = 0; i < 5; i++) begin
            rnd_pkt();
            in_valid = 1'b1;
            step();
        end
        #1;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_count", 64'(count), 64'd4);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();

        // Steady enq+deq at count 2 across pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rnd_pkt();
            in_valid = 1'b1;
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rnd_pkt();
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();

        // Flush at count 3 while both sides want to transfer
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rnd_pkt();
            in_valid = 1'b1;
            step();
        end
        rnd_pkt();
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        step();

        // Jump in the last slot: delay slot falls in the next packet
        in_inst = {32'h0800_0010, 32'h0, 32'h0, 32'h0};
        in_pc = 32'h0000_2000;
        in_sct_valid = 1'b1;
        in_valid = 1'b1;
`ifdef PDQ_BYPASS_EN
        out_ready = 1'b1;
        #1;
        chk("byp_out_valid", 64'(out_valid), 64'd1);
        chk("j_first_br", 64'(out_first_br), 64'd3);
        chk("j_ds_next", 64'(out_ds_next), 64'd1);
        chk("j_sel3", 64'(out_sel[19:15]), 64'(5'b00110));
        step();
        in_valid = 1'b0;
        #1;
        chk("byp_count", 64'(count), 64'd0);
        step();
`else
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        #1;
        chk("j_first_br", 64'(out_first_br), 64'd3);
        chk("j_ds_next", 64'(out_ds_next), 64'd1);
        chk("j_sel3", 64'(out_sel[19:15]), 64'(5'b00110));
        out_ready = 1'b1;
        step();
`endif

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rnd_pkt();
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 19) == 0);
            in_sct_valid = ($urandom_range(0, 7) != 0);
            step();
        end
        flush = 1'b0;

        // Asynchronous reset in the middle of traffic
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rnd_pkt();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_out_sel", 64'(out_sel), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int n = 0; n < 100; n++) begin
            rnd_pkt();
            in_valid = ($urandom_range(0, 1) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            in_sct_valid = 1'b1;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
